// File: rtl/dma_batch_ctrl.sv
// Batch sequencer over the rdma/wdma pair: one ap_start runs num_tiles tiles back-to-back,
// stepping both addresses by their strides per tile.
//   state  | meaning
//   IDLE   | waiting for a start edge
//   LAUNCH | issuing starts to both engines, collecting readys
//   WAIT   | collecting dones, then advance or finish
//   DONE   | one-cycle end-of-batch state
module dma_batch_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_idle,
    output logic                  ap_ready,
    output logic                  ap_done,
    input  logic [CNT_WIDTH-1:0]  num_tiles,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] rdma_base,
    input  logic [ADDR_WIDTH-1:0] rdma_stride,
    input  logic [ADDR_WIDTH-1:0] rdma_bytes,
    input  logic [ADDR_WIDTH-1:0] wdma_base,
    input  logic [ADDR_WIDTH-1:0] wdma_stride,
    input  logic [ADDR_WIDTH-1:0] wdma_bytes,
    output logic                  rdma_ap_start,
    input  logic                  rdma_ap_ready,
    input  logic                  rdma_ap_done,
    output logic [ADDR_WIDTH-1:0] rdma_mem,
    output logic [ADDR_WIDTH-1:0] rdma_transfer_byte,
    output logic                  wdma_ap_start,
    input  logic                  wdma_ap_ready,
    input  logic                  wdma_ap_done,
    output logic [ADDR_WIDTH-1:0] wdma_mem,
    output logic [ADDR_WIDTH-1:0] wdma_transfer_byte,
    output logic [CNT_WIDTH-1:0]  tiles_done,
    output logic                  aborted
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

    state_t state, state_nxt;

    logic                  ap_start_q;
    logic [CNT_WIDTH-1:0]  num_q;
    logic [ADDR_WIDTH-1:0] rdma_stride_q, wdma_stride_q;
    logic                  launched_q, abort_q;
    logic                  rdma_rdy_q, wdma_rdy_q, rdma_done_q, wdma_done_q;

    logic start_edge, accept, issue, tile_fin, last_tile, stop_batch;
    logic rdma_rdy_now, wdma_rdy_now, rdma_fin, wdma_fin;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= S_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        issue        = 1'b0;
        tile_fin     = 1'b0;
        stop_batch   = 1'b0;
        start_edge   = ap_start & ~ap_start_q;
        ap_idle      = (state == S_IDLE);
        rdma_rdy_now = rdma_rdy_q | (rdma_ap_start & rdma_ap_ready);
        wdma_rdy_now = wdma_rdy_q | (wdma_ap_start & wdma_ap_ready);
        // A done pulse in the deciding cycle counts, so the last done pair reaches DONE directly.
        rdma_fin     = rdma_done_q | rdma_ap_done;
        wdma_fin     = wdma_done_q | wdma_ap_done;
        last_tile    = ((tiles_done + CNT_WIDTH'(1)) == num_q);
        case (state)
            S_IDLE: begin
                if (start_edge) begin
                    accept    = 1'b1;
                    state_nxt = (num_tiles != '0) ? S_LAUNCH : S_DONE;
                end
            end
            S_LAUNCH: begin
                if (!launched_q)                       issue     = 1'b1;
                else if (rdma_rdy_now && wdma_rdy_now) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (rdma_fin && wdma_fin) begin
                    tile_fin   = 1'b1;
                    stop_batch = last_tile | abort_q | abort;
                    state_nxt  = stop_batch ? S_DONE : S_LAUNCH;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ap_start_q         <= 1'b0;
            ap_done            <= 1'b0;
            ap_ready           <= 1'b0;
            num_q              <= '0;
            rdma_stride_q      <= '0;
            wdma_stride_q      <= '0;
            rdma_mem           <= '0;
            wdma_mem           <= '0;
            rdma_transfer_byte <= '0;
            wdma_transfer_byte <= '0;
            rdma_ap_start      <= 1'b0;
            wdma_ap_start      <= 1'b0;
            launched_q         <= 1'b0;
            rdma_rdy_q         <= 1'b0;
            wdma_rdy_q         <= 1'b0;
            rdma_done_q        <= 1'b0;
            wdma_done_q        <= 1'b0;
            abort_q            <= 1'b0;
            tiles_done         <= '0;
            aborted            <= 1'b0;
        end else begin
            ap_start_q <= ap_start;
            ap_done    <= (state == S_DONE);
            ap_ready   <= (state == S_DONE);
            if (accept) begin
                num_q              <= num_tiles;
                rdma_mem           <= rdma_base;
                wdma_mem           <= wdma_base;
                rdma_stride_q      <= rdma_stride;
                wdma_stride_q      <= wdma_stride;
                rdma_transfer_byte <= rdma_bytes;
                wdma_transfer_byte <= wdma_bytes;
                tiles_done         <= '0;
                aborted            <= 1'b0;
                abort_q            <= 1'b0;
            end
            if (state == S_LAUNCH || state == S_WAIT) abort_q <= abort_q | abort;
            if (issue) begin
                rdma_ap_start <= 1'b1;
                wdma_ap_start <= 1'b1;
                launched_q    <= 1'b1;
            end
            if (rdma_ap_start && rdma_ap_ready) begin
                rdma_ap_start <= 1'b0;
                rdma_rdy_q    <= 1'b1;
            end
            if (wdma_ap_start && wdma_ap_ready) begin
                wdma_ap_start <= 1'b0;
                wdma_rdy_q    <= 1'b1;
            end
            if (launched_q && rdma_ap_done) rdma_done_q <= 1'b1;
            if (launched_q && wdma_ap_done) wdma_done_q <= 1'b1;
            // Tile completion wins over the flag sets above: it consumes this tile's handshakes.
            if (tile_fin) begin
                tiles_done  <= tiles_done + CNT_WIDTH'(1);
                rdma_mem    <= rdma_mem + rdma_stride_q;
                wdma_mem    <= wdma_mem + wdma_stride_q;
                aborted     <= stop_batch & ~last_tile;
                launched_q  <= 1'b0;
                rdma_rdy_q  <= 1'b0;
                wdma_rdy_q  <= 1'b0;
                rdma_done_q <= 1'b0;
                wdma_done_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dma_batch_ctrl.sv
// Directed bench for dma_batch_ctrl: table of batch vectors driven against two behavioural
// DMA engines, plus hand-written reset, latency and async-reset sequences.
module tb_dma_batch_ctrl;

    logic        ap_clk, ap_rst_n, ap_start, ap_idle, ap_ready, ap_done, abort;
    logic [15:0] num_tiles, tiles_done;
    logic [31:0] rdma_base, rdma_stride, rdma_bytes, wdma_base, wdma_stride, wdma_bytes;
    logic        rdma_ap_start, rdma_ap_ready, rdma_ap_done;
    logic        wdma_ap_start, wdma_ap_ready, wdma_ap_done;
    logic [31:0] rdma_mem, rdma_transfer_byte, wdma_mem, wdma_transfer_byte;
    logic        aborted;

    dma_batch_ctrl dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_idle(ap_idle),
        .ap_ready(ap_ready), .ap_done(ap_done), .num_tiles(num_tiles), .abort(abort),
        .rdma_base(rdma_base), .rdma_stride(rdma_stride), .rdma_bytes(rdma_bytes),
        .wdma_base(wdma_base), .wdma_stride(wdma_stride), .wdma_bytes(wdma_bytes),
        .rdma_ap_start(rdma_ap_start), .rdma_ap_ready(rdma_ap_ready), .rdma_ap_done(rdma_ap_done),
        .rdma_mem(rdma_mem), .rdma_transfer_byte(rdma_transfer_byte),
        .wdma_ap_start(wdma_ap_start), .wdma_ap_ready(wdma_ap_ready), .wdma_ap_done(wdma_ap_done),
        .wdma_mem(wdma_mem), .wdma_transfer_byte(wdma_transfer_byte),
        .tiles_done(tiles_done), .aborted(aborted)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Behavioural engines: ready after r_rdy_dly cycles, done r_done_dly cycles after ready (0 = same cycle).
    int r_rdy_dly = 0, r_done_dly = 1, w_rdy_dly = 0, w_done_dly = 1;
    logic [31:0] r_addrs[$];
    logic [31:0] w_addrs[$];

    initial begin : rdma_engine
        rdma_ap_ready = 1'b0;
        rdma_ap_done  = 1'b0;
        forever begin
            @(negedge ap_clk);
            if (rdma_ap_start === 1'b1) begin
                r_addrs.push_back(rdma_mem);
                repeat (r_rdy_dly) @(negedge ap_clk);
                rdma_ap_ready = 1'b1;
                if (r_done_dly == 0) rdma_ap_done = 1'b1;
                @(negedge ap_clk);
                rdma_ap_ready = 1'b0;
                rdma_ap_done  = 1'b0;
                if (r_done_dly > 0) begin
                    repeat (r_done_dly - 1) @(negedge ap_clk);
                    rdma_ap_done = 1'b1;
                    @(negedge ap_clk);
                    rdma_ap_done = 1'b0;
                end
            end
        end
    end

    initial begin : wdma_engine
        wdma_ap_ready = 1'b0;
        wdma_ap_done  = 1'b0;
        forever begin
            @(negedge ap_clk);
            if (wdma_ap_start === 1'b1) begin
                w_addrs.push_back(wdma_mem);
                repeat (w_rdy_dly) @(negedge ap_clk);
                wdma_ap_ready = 1'b1;
                if (w_done_dly == 0) wdma_ap_done = 1'b1;
                @(negedge ap_clk);
                wdma_ap_ready = 1'b0;
                wdma_ap_done  = 1'b0;
                if (w_done_dly > 0) begin
                    repeat (w_done_dly - 1) @(negedge ap_clk);
                    wdma_ap_done = 1'b1;
                    @(negedge ap_clk);
                    wdma_ap_done = 1'b0;
                end
            end
        end
    end

    typedef struct {
        int          num;
        logic [31:0] rbase, rstride, wbase, wstride, rbytes, wbytes;
        int          r_rdy, r_done, w_rdy, w_done;
        int          abort_tile;   // pulse abort once this many rdma starts were seen (0 = never)
        bit          poke;         // extra ap_start edges while the batch runs
        int          exp_tiles;
        bit          exp_aborted;
        logic [31:0] exp_r_last, exp_w_last;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v, input string tag);
        int n_done, fin;
        bit ab_sent;
        logic [31:0] exp_addr;
        @(negedge ap_clk);
        r_addrs.delete();
        w_addrs.delete();
        num_tiles   = 16'(v.num);
        rdma_base   = v.rbase;  rdma_stride = v.rstride; rdma_bytes = v.rbytes;
        wdma_base   = v.wbase;  wdma_stride = v.wstride; wdma_bytes = v.wbytes;
        r_rdy_dly   = v.r_rdy;  r_done_dly  = v.r_done;
        w_rdy_dly   = v.w_rdy;  w_done_dly  = v.w_done;
        ap_start    = 1'b1;
        n_done = 0; fin = -1; ab_sent = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge ap_clk);
            if (ap_done === 1'b1) n_done++;
            if (c == 0) ap_start = 1'b0;
            if (v.poke && (c == 3 || c == 6)) ap_start = 1'b1;
            if (v.poke && (c == 4 || c == 7)) ap_start = 1'b0;
            if (abort) abort = 1'b0;
            else if (v.abort_tile > 0 && !ab_sent && r_addrs.size() == v.abort_tile) begin
                abort   = 1'b1;
                ab_sent = 1'b1;
            end
            if (n_done > 0 && fin < 0) fin = c;
            if (fin >= 0 && c >= fin + 6) break;
        end
        abort    = 1'b0;
        ap_start = 1'b0;
        chk({tag, "_done_pulses"}, 64'(n_done), 64'd1);
        chk({tag, "_tiles_done"}, tiles_done, 64'(v.exp_tiles));
        chk({tag, "_aborted"}, aborted, v.exp_aborted);
        chk({tag, "_idle"}, ap_idle, 1'b1);
        chk({tag, "_rdma_starts"}, 64'(r_addrs.size()), 64'(v.exp_tiles));
        chk({tag, "_wdma_starts"}, 64'(w_addrs.size()), 64'(v.exp_tiles));
        if (v.exp_tiles > 0) begin
            chk({tag, "_rdma_bytes"}, rdma_transfer_byte, v.rbytes);
            chk({tag, "_wdma_bytes"}, wdma_transfer_byte, v.wbytes);
            if (r_addrs.size() > 0) chk({tag, "_rdma_last"}, r_addrs[r_addrs.size()-1], v.exp_r_last);
            if (w_addrs.size() > 0) chk({tag, "_wdma_last"}, w_addrs[w_addrs.size()-1], v.exp_w_last);
            for (int i = 0; i < r_addrs.size(); i++) begin
                exp_addr = v.rbase + 32'(i) * v.rstride;
                chk($sformatf("%s_rdma_addr%0d", tag, i), r_addrs[i], exp_addr);
            end
            for (int i = 0; i < w_addrs.size(); i++) begin
                exp_addr = v.wbase + 32'(i) * v.wstride;
                chk($sformatf("%s_wdma_addr%0d", tag, i), w_addrs[i], exp_addr);
            end
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n_done;
        vecs[0] = '{3, 32'h1000, 32'h40, 32'h8000, 32'h40, 32'd64, 32'd64, 0, 1, 0, 1, 0, 1'b1,
                    3, 1'b0, 32'h1080, 32'h8080};
        vecs[1] = '{0, 32'h2000, 32'h40, 32'h9000, 32'h40, 32'd16, 32'd16, 0, 1, 0, 1, 0, 1'b0,
                    0, 1'b0, 32'h0, 32'h0};
        vecs[2] = '{1, 32'h3000, 32'h10, 32'h9000, 32'h10, 32'd32, 32'd48, 0, 1, 6, 2, 0, 1'b0,
                    1, 1'b0, 32'h3000, 32'h9000};
        vecs[3] = '{2, 32'h4000, 32'h100, 32'hA000, 32'h80, 32'd256, 32'd128, 2, 0, 0, 0, 0, 1'b0,
                    2, 1'b0, 32'h4100, 32'hA080};
        vecs[4] = '{5, 32'h5000, 32'h40, 32'hB000, 32'h40, 32'd64, 32'd64, 0, 3, 1, 2, 2, 1'b0,
                    2, 1'b1, 32'h5040, 32'hB040};
        vecs[5] = '{2, 32'hFFFF_FFC0, 32'h40, 32'h7FFF_FFF0, 32'h20, 32'd64, 32'd32, 0, 1, 0, 1, 0, 1'b0,
                    2, 1'b0, 32'h0000_0000, 32'h8000_0010};
        vecs[6] = '{2, 32'h100, 32'h8, 32'h200, 32'h8, 32'd8, 32'd8, 0, 3, 0, 3, 2, 1'b0,
                    2, 1'b0, 32'h108, 32'h208};

        // Reset values, with ap_start held high through reset release.
        ap_rst_n = 1'b0; ap_start = 1'b1; abort = 1'b0; num_tiles = '0;
        rdma_base = '0; rdma_stride = '0; rdma_bytes = '0;
        wdma_base = '0; wdma_stride = '0; wdma_bytes = '0;
        #12;
        chk("rst_idle", ap_idle, 1'b1);
        chk("rst_done", {ap_done, ap_ready}, 2'b00);
        chk("rst_starts", {rdma_ap_start, wdma_ap_start}, 2'b00);
        chk("rst_mem", {rdma_mem, wdma_mem}, 64'd0);
        chk("rst_bytes", {rdma_transfer_byte, wdma_transfer_byte}, 64'd0);
        chk("rst_tiles_aborted", {tiles_done, aborted}, 17'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        n_done = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge ap_clk);
            if (ap_done === 1'b1) n_done++;
        end
        ap_start = 1'b0;
        chk("held_start_done_pulses", 64'(n_done), 64'd1);

        // Exact latencies: start two cycles after the edge, ap_done two cycles after the last done.
        repeat (3) @(negedge ap_clk);
        r_addrs.delete(); w_addrs.delete();
        num_tiles = 16'd1; rdma_base = 32'h600; wdma_base = 32'h700;
        r_rdy_dly = 0; r_done_dly = 1; w_rdy_dly = 0; w_done_dly = 1;
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        chk("lat_start_early", {rdma_ap_start, wdma_ap_start}, 2'b00);
        @(negedge ap_clk);
        chk("lat_start_on_time", {rdma_ap_start, wdma_ap_start}, 2'b11);
        chk("lat_mem_stable", {rdma_mem, wdma_mem}, {32'h600, 32'h700});
        @(negedge ap_clk);
        @(negedge ap_clk);
        chk("lat_done_early", ap_done, 1'b0);
        @(negedge ap_clk);
        chk("lat_done_on_time", {ap_done, ap_ready}, 2'b11);
        chk("lat_tiles", tiles_done, 16'd1);
        @(negedge ap_clk);
        chk("lat_done_single", ap_done, 1'b0);

        // Zero-length batch latency.
        repeat (3) @(negedge ap_clk);
        num_tiles = '0;
        ap_start  = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        chk("zero_done_early", ap_done, 1'b0);
        @(negedge ap_clk);
        chk("zero_done_on_time", ap_done, 1'b1);
        @(negedge ap_clk);
        chk("zero_done_single", ap_done, 1'b0);
        repeat (3) @(negedge ap_clk);

        for (int i = 0; i < 7; i++) begin
            if (i == 5) begin
                // Abort while idle must be ignored by the following batch.
                abort = 1'b1;
                repeat (3) @(negedge ap_clk);
                abort = 1'b0;
            end
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Async reset in the middle of WAIT, then a clean batch.
        @(negedge ap_clk);
        r_addrs.delete(); w_addrs.delete();
        num_tiles = 16'd2; rdma_base = 32'hC000; rdma_stride = 32'h40; rdma_bytes = 32'd64;
        r_rdy_dly = 0; r_done_dly = 20; w_rdy_dly = 0; w_done_dly = 20;
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (5) @(negedge ap_clk);
        chk("mid_wait_busy", ap_idle, 1'b0);
        #2 ap_rst_n = 1'b0;
        #1;
        chk("async_rst_idle", ap_idle, 1'b1);
        chk("async_rst_starts", {rdma_ap_start, wdma_ap_start}, 2'b00);
        chk("async_rst_mem", {rdma_mem, wdma_mem}, 64'd0);
        chk("async_rst_bytes", rdma_transfer_byte, 32'd0);
        chk("async_rst_tiles", {tiles_done, aborted, ap_done}, 18'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (40) @(negedge ap_clk);
        run_vec(vecs[0], "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
